rc4_decrypt_core: RTL and testbench

- Parametrised RC4 engine that runs the complete decryption sequence from one start pulse: S-array initialisation, key scheduling (KSA) and keystream generation/XOR (PRGA).
- Drives the external 256x8 S working RAM, the encrypted-message ROM and the decrypted-message RAM.
- Optionally checks each plaintext byte and aborts early on an invalid character. This is the building block for a key-search controller.

---
 rtl/rc4_decrypt_core.sv | 221 ++++++++++++++++++++++
 tb/tb_rc4_decrypt_core.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_core.sv
// rc4_decrypt_core: one-shot RC4 engine (S init, key schedule, keystream XOR)
// driving an external S RAM, cipher ROM and plaintext RAM; optional early abort on bad text.
module rc4_decrypt_core #(
    parameter int KEY_BYTES  = 3,
    parameter int MSG_LEN    = 32,
    parameter int MSG_ADDR_W = 5,
    parameter bit CHECK_EN   = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [8*KEY_BYTES-1:0]  secret_key,
    output logic [7:0]              s_address,
    output logic [7:0]              s_data,
    output logic                    s_wren,
    input  logic [7:0]              s_q,
    output logic [MSG_ADDR_W-1:0]   rom_address,
    input  logic [7:0]              rom_q,
    output logic [MSG_ADDR_W-1:0]   dec_address,
    output logic [7:0]              dec_data,
    output logic                    dec_wren,
    output logic                    busy,
    output logic                    done,
    output logic                    key_valid
);
    localparam int KW = 8 * KEY_BYTES;
    localparam logic [MSG_ADDR_W-1:0] K_LAST = MSG_ADDR_W'(MSG_LEN - 1);

    typedef enum logic [4:0] {
        IDLE, INIT,
        K_RD_SI, K_WT_SI, K_RD_SJ, K_WT_SJ, K_WR_SI, K_WR_SJ,
        P_RD_SI, P_WT_SI, P_RD_SJ, P_WT_SJ, P_WR_SI, P_WR_SJ,
        P_RD_F, P_WT_F, P_WR_DEC, DONE
    } state_t;

    state_t state, state_n;
    logic [7:0] i, i_n, j, j_n, si, si_n, sj, sj_n, c, c_n;
    logic [MSG_ADDR_W-1:0] k, k_n;
    logic [KW-1:0] key, key_n;
    logic [7:0] s_address_n, s_data_n, dec_data_n;
    logic [MSG_ADDR_W-1:0] rom_address_n, dec_address_n;
    logic s_wren_n, dec_wren_n, busy_n, done_n, key_valid_n;
    logic [7:0] j_ksa, j_prga;
    logic pt_ok;

    // The key register rotates one byte per KSA step, so its top byte is always key[i mod KEY_BYTES].
    assign j_ksa  = j + s_q + key[KW-1 -: 8];
    assign j_prga = j + s_q;
    assign pt_ok  = !CHECK_EN || dec_data == 8'h20 || (dec_data >= 8'h61 && dec_data <= 8'h7a);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            si          <= '0;
            sj          <= '0;
            c           <= '0;
            key         <= '0;
            s_address   <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            rom_address <= '0;
            dec_address <= '0;
            dec_data    <= '0;
            dec_wren    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            key_valid   <= 1'b0;
        end else begin
            state       <= state_n;
            i           <= i_n;
            j           <= j_n;
            k           <= k_n;
            si          <= si_n;
            sj          <= sj_n;
            c           <= c_n;
            key         <= key_n;
            s_address   <= s_address_n;
            s_data      <= s_data_n;
            s_wren      <= s_wren_n;
            rom_address <= rom_address_n;
            dec_address <= dec_address_n;
            dec_data    <= dec_data_n;
            dec_wren    <= dec_wren_n;
            busy        <= busy_n;
            done        <= done_n;
            key_valid   <= key_valid_n;
        end
    end

    // Outputs are registered, so each branch loads the values the *next* state presents.
    always_comb begin
        state_n       = state;
        i_n           = i;
        j_n           = j;
        k_n           = k;
        si_n          = si;
        sj_n          = sj;
        c_n           = c;
        key_n         = key;
        s_address_n   = s_address;
        s_data_n      = s_data;
        s_wren_n      = 1'b0;
        rom_address_n = rom_address;
        dec_address_n = dec_address;
        dec_data_n    = dec_data;
        dec_wren_n    = 1'b0;
        busy_n        = busy;
        done_n        = 1'b0;
        key_valid_n   = key_valid;
        case (state)
            IDLE: if (start) begin
                state_n     = INIT;
                key_n       = secret_key;
                i_n         = '0;
                s_address_n = '0;
                s_data_n    = '0;
                s_wren_n    = 1'b1;
                busy_n      = 1'b1;
                key_valid_n = 1'b0;
            end
            INIT: if (i == 8'hff) begin
                state_n     = K_RD_SI;
                i_n         = '0;
                j_n         = '0;
                s_address_n = '0;
            end else begin
                i_n         = i + 8'd1;
                s_address_n = i + 8'd1;
                s_data_n    = i + 8'd1;
                s_wren_n    = 1'b1;
            end
            K_RD_SI: state_n = K_WT_SI;
            K_WT_SI: begin
                state_n     = K_RD_SJ;
                si_n        = s_q;
                j_n         = j_ksa;
                s_address_n = j_ksa;
            end
            K_RD_SJ: state_n = K_WT_SJ;
            K_WT_SJ: begin
                state_n     = K_WR_SI;
                s_address_n = i;
                s_data_n    = s_q;
                s_wren_n    = 1'b1;
            end
            K_WR_SI: begin
                state_n     = K_WR_SJ;
                s_address_n = j;
                s_data_n    = si;
                s_wren_n    = 1'b1;
            end
            K_WR_SJ: begin
                key_n = (key << 8) | (key >> (KW - 8));
                if (i == 8'hff) begin
                    state_n       = P_RD_SI;
                    i_n           = 8'd1;
                    j_n           = '0;
                    k_n           = '0;
                    s_address_n   = 8'd1;
                    rom_address_n = '0;
                end else begin
                    state_n     = K_RD_SI;
                    i_n         = i + 8'd1;
                    s_address_n = i + 8'd1;
                end
            end
            P_RD_SI: state_n = P_WT_SI;
            P_WT_SI: begin
                state_n     = P_RD_SJ;
                si_n        = s_q;
                c_n         = rom_q;
                j_n         = j_prga;
                s_address_n = j_prga;
            end
            P_RD_SJ: state_n = P_WT_SJ;
            P_WT_SJ: begin
                state_n     = P_WR_SI;
                sj_n        = s_q;
                s_address_n = i;
                s_data_n    = s_q;
                s_wren_n    = 1'b1;
            end
            P_WR_SI: begin
                state_n     = P_WR_SJ;
                s_address_n = j;
                s_data_n    = si;
                s_wren_n    = 1'b1;
            end
            P_WR_SJ: begin
                state_n     = P_RD_F;
                s_address_n = si + sj;
            end
            P_RD_F: state_n = P_WT_F;
            P_WT_F: begin
                state_n       = P_WR_DEC;
                dec_address_n = k;
                dec_data_n    = s_q ^ c;
                dec_wren_n    = 1'b1;
            end
            P_WR_DEC: if (!pt_ok || k == K_LAST) begin
                state_n     = DONE;
                done_n      = 1'b1;
                busy_n      = 1'b0;
                key_valid_n = pt_ok;
                s_address_n = '0;
                s_data_n    = '0;
            end else begin
                state_n       = P_RD_SI;
                k_n           = k + 1'b1;
                i_n           = i + 8'd1;
                s_address_n   = i + 8'd1;
                rom_address_n = k + 1'b1;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rc4_decrypt_core.sv
// tb_rc4_decrypt_core: scoreboard bench over three instances:
// 0 = Key/Plaintext without check, 1 = Wiki/pedia with check, 2 = Key/Plaintext with check (abort).
module tb_rc4_decrypt_core;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_start = 0;
    always @(posedge clock) cyc++;

    localparam logic [71:0] PT     = "Plaintext";
    localparam logic [71:0] PT_ROM = 72'hBBF316E8D940AF0AD3;
    localparam logic [39:0] WK     = "pedia";
    localparam logic [39:0] WK_ROM = 40'h1021BF0420;

    logic       start [3];
    logic [7:0] s_address [3];
    logic [7:0] s_data [3];
    logic       s_wren [3];
    logic [4:0] rom_address [3];
    logic [4:0] dec_address [3];
    logic [7:0] dec_data [3];
    logic       dec_wren [3];
    logic       busy [3];
    logic       done [3];
    logic       key_valid [3];
    logic [12:0] exp_q [3][$];
    int last_wr [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] idle_vec(input int m);
        return {busy[m], done[m], key_valid[m], s_wren[m], dec_wren[m],
                |s_address[m], |s_data[m], |rom_address[m], |dec_address[m], |dec_data[m]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int KB = g == 1 ? 4 : 3;
        localparam int ML = g == 1 ? 5 : 9;
        localparam logic [8*KB-1:0] KEY = (8*KB)'(g == 1 ? 32'h57696B69 : 32'h004B6579);
        logic [7:0] s_mem [256];
        logic [7:0] rom [32];
        logic [7:0] sq, rq;

        initial begin
            logic [71:0] rv;
            rv = g == 1 ? {WK_ROM, 32'h0} : PT_ROM;
            for (int n = 0; n < ML; n++) rom[n] = rv[71-8*n -: 8];
        end

        always @(posedge clock) begin
            if (s_wren[g]) s_mem[s_address[g]] <= s_data[g];
            sq <= s_mem[s_address[g]];
            rq <= rom[rom_address[g]];
        end

        always @(negedge clock) if (dec_wren[g]) begin
            check("dec_pending", exp_q[g].size() > 0, 1);
            if (exp_q[g].size() > 0) check("dec_wr", {dec_address[g], dec_data[g]}, exp_q[g].pop_front());
            last_wr[g] = cyc;
        end

        rc4_decrypt_core #(.KEY_BYTES(KB), .MSG_LEN(ML), .MSG_ADDR_W(5), .CHECK_EN(g != 0)) dut (
            .clock(clock),
            .reset_n(reset_n),
            .start(start[g]),
            .secret_key(KEY),
            .s_address(s_address[g]),
            .s_data(s_data[g]),
            .s_wren(s_wren[g]),
            .s_q(sq),
            .rom_address(rom_address[g]),
            .rom_q(rq),
            .dec_address(dec_address[g]),
            .dec_data(dec_data[g]),
            .dec_wren(dec_wren[g]),
            .busy(busy[g]),
            .done(done[g]),
            .key_valid(key_valid[g])
        );
    end

    // Call at a falling edge; returns at the falling edge of the first busy cycle.
    task automatic launch(input int idx);
        logic [71:0] pt;
        int n;
        pt = idx == 1 ? {WK, 32'h0} : PT;
        n = idx == 0 ? 9 : idx == 1 ? 5 : 1;
        for (int m = 0; m < n; m++) exp_q[idx].push_back({5'(m), pt[71-8*m -: 8]});
        start[idx] = 1'b1;
        @(negedge clock);
        start[idx] = 1'b0;
        t_start = cyc;
        check("busy_on", busy[idx], 1);
    endtask

    task automatic finish_run(input int idx, input logic kv, output int lat);
        int n;
        n = 0;
        while (!done[idx] && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("done_seen", done[idx], 1);
        lat = cyc - t_start;
        check("key_valid", key_valid[idx], kv);
        check("busy_at_done", busy[idx], 0);
        check("sb_empty", exp_q[idx].size(), 0);
        if (idx == 2) check("abort_gap", cyc - last_wr[2], 1);
        exp_q[idx].delete();
        @(negedge clock);
        check("done_pulse", done[idx], 0);
        check("kv_hold", key_valid[idx], kv);
        check("s_bus_idle", {s_wren[idx], s_address[idx], s_data[idx]}, 0);
    endtask

    initial begin
        int lat0, lat;
        reset_n = 1'b0;
        for (int m = 0; m < 3; m++) start[m] = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        repeat (100) begin
            @(negedge clock);
            for (int m = 0; m < 3; m++) check("idle", idle_vec(m), 0);
        end

        launch(0);
        for (int n = 0; n < 256; n++) begin
            check("init_wr", {s_wren[0], s_address[0], s_data[0]}, {1'b1, 8'(n), 8'(n)});
            @(negedge clock);
        end
        check("init_end", s_wren[0], 0);
        finish_run(0, 1'b1, lat0);

        launch(1);
        finish_run(1, 1'b1, lat);

        launch(2);
        finish_run(2, 1'b0, lat);

        launch(0);
        repeat (600) @(negedge clock);
        check("busy_mid", busy[0], 1);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        finish_run(0, 1'b1, lat);
        check("latency_stray", lat, lat0);

        launch(0);
        repeat (700) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check("async_rst", idle_vec(0), 0);
        exp_q[0].delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        launch(0);
        finish_run(0, 1'b1, lat);
        check("latency_rst", lat, lat0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
